// File: rtl/sdram_arbit_pkg.sv
// Shared SDRAM command encodings, bus widths and arbiter state encoding
// for the SDRAM command-bus arbiter and its refresh sequencer.
package sdram_arbit_pkg;

  localparam int ADDR_W = 13;
  localparam int BANK_W = 2;
  localparam int A10    = 10;

  // {cs_n, ras_n, cas_n, we_n}
  typedef logic [3:0] sdram_cmd_t;

  localparam sdram_cmd_t CMD_NOP  = 4'b0111;
  localparam sdram_cmd_t CMD_PRE  = 4'b0010;
  localparam sdram_cmd_t CMD_AREF = 4'b0001;
  localparam sdram_cmd_t CMD_MSET = 4'b0000;
  localparam sdram_cmd_t CMD_ACT  = 4'b0011;
  localparam sdram_cmd_t CMD_RD   = 4'b0101;
  localparam sdram_cmd_t CMD_WR   = 4'b0100;

  // A10 high on PRECHARGE selects all banks
  localparam logic [ADDR_W-1:0] PRE_ALL_ADDR = ADDR_W'(1) << A10;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } arb_state_t;

endpackage

// File: rtl/sdram_arbit_if.sv
// Requester, init-block and SDRAM pad signals around the command-bus arbiter.
// slave = arbiter side, master = the surrounding blocks / pads.
interface sdram_arbit_if;
  import sdram_arbit_pkg::*;

  sdram_cmd_t              init_cmd;
  logic [ADDR_W-1:0]       init_addr;
  logic                    flag_init_end;

  logic                    wr_req;
  logic                    rd_req;
  sdram_cmd_t              wr_cmd;
  sdram_cmd_t              rd_cmd;
  logic [ADDR_W-1:0]       wr_addr;
  logic [ADDR_W-1:0]       rd_addr;
  logic [BANK_W-1:0]       wr_bank;
  logic [BANK_W-1:0]       rd_bank;
  logic                    wr_end;
  logic                    rd_end;

  logic                    wr_en;
  logic                    rd_en;
  logic                    ref_pending;

  logic                    sdram_cke;
  logic                    sdram_cs_n;
  logic                    sdram_ras_n;
  logic                    sdram_cas_n;
  logic                    sdram_we_n;
  logic [BANK_W-1:0]       sdram_bank;
  logic [ADDR_W-1:0]       sdram_addr;

  modport slave (
    input  init_cmd, init_addr, flag_init_end,
           wr_req, rd_req, wr_cmd, rd_cmd, wr_addr, rd_addr,
           wr_bank, rd_bank, wr_end, rd_end,
    output wr_en, rd_en, ref_pending,
           sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
           sdram_bank, sdram_addr
  );

  modport master (
    output init_cmd, init_addr, flag_init_end,
           wr_req, rd_req, wr_cmd, rd_cmd, wr_addr, rd_addr,
           wr_bank, rd_bank, wr_end, rd_end,
    input  wr_en, rd_en, ref_pending,
           sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
           sdram_bank, sdram_addr
  );

endinterface

// File: rtl/sdram_arbit_aref.sv
// Periodic auto-refresh timer plus the PRE-all / AREF command sequencer
// that runs while the arbiter sits in its AREF state.
module sdram_aref
  import sdram_arbit_pkg::*;
#(
  parameter int REF_PERIOD = 390,
  parameter int T_RP       = 2,
  parameter int T_RFC      = 4
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              init_done,
  input  logic              start,
  output logic              ref_pending,
  output sdram_cmd_t        aref_cmd,
  output logic [ADDR_W-1:0] aref_addr,
  output logic              aref_done
);

  localparam int SEQ_LEN = T_RP + T_RFC + 2;
  localparam int CNT_W   = $clog2(REF_PERIOD);
  localparam int K_W     = $clog2(SEQ_LEN);

  logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             pend_q, pend_d;
  logic             wrap;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    wrap      = init_done && (ref_cnt_q == CNT_W'(REF_PERIOD - 1));
    ref_cnt_d = ref_cnt_q;
    if (init_done) ref_cnt_d = wrap ? '0 : ref_cnt_q + 1'b1;

    aref_done = start && (k_q == K_W'(SEQ_LEN - 1));
    k_d       = (start && !aref_done) ? k_q + 1'b1 : '0;
    // A wrap landing on the exit cycle must not be lost
    pend_d    = wrap || (pend_q && !aref_done);

    aref_cmd  = CMD_NOP;
    aref_addr = '0;
    if (start) begin
      if (k_q == '0) begin
        aref_cmd  = CMD_PRE;
        aref_addr = PRE_ALL_ADDR;
      end else if (k_q == K_W'(T_RP + 1)) begin
        aref_cmd  = CMD_AREF;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      ref_cnt_q <= '0;
      k_q       <= '0;
      pend_q    <= 1'b0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      k_q       <= k_d;
      pend_q    <= pend_d;
    end
  end

  assign ref_pending = pend_q;

endmodule

// File: rtl/sdram_arbit.sv
// Sole owner of the SDRAM command/address pins: passes init through, then
// arbitrates refresh > write > read onto one command bus.
module sdram_arbit
  import sdram_arbit_pkg::*;
#(
  parameter int REF_PERIOD = 390,
  parameter int T_RP       = 2,
  parameter int T_RFC      = 4
) (
  input  logic          sclk,
  input  logic          s_rst_n,
  sdram_arbit_if.slave  bus
);

  arb_state_t        state_q, state_d;
  logic              cke_q;
  sdram_cmd_t        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              aref_done;
  sdram_cmd_t        pin_cmd;

  sdram_aref #(
    .REF_PERIOD (REF_PERIOD),
    .T_RP       (T_RP),
    .T_RFC      (T_RFC)
  ) u_aref (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .init_done   (state_q != ST_INIT),
    .start       (state_q == ST_AREF),
    .ref_pending (bus.ref_pending),
    .aref_cmd    (aref_cmd),
    .aref_addr   (aref_addr),
    .aref_done   (aref_done)
  );

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= ST_INIT;
      cke_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cke_q   <= 1'b1;
    end
  end

  // Refresh never pre-empts an owner; it is only taken from ARBIT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:  if (bus.flag_init_end) state_d = ST_ARBIT;
      ST_ARBIT: begin
        if (bus.ref_pending)  state_d = ST_AREF;
        else if (bus.wr_req)  state_d = ST_WRITE;
        else if (bus.rd_req)  state_d = ST_READ;
      end
      ST_AREF:  if (aref_done)  state_d = ST_ARBIT;
      ST_WRITE: if (bus.wr_end) state_d = ST_ARBIT;
      ST_READ:  if (bus.rd_end) state_d = ST_ARBIT;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    bus.wr_en      = (state_q == ST_WRITE);
    bus.rd_en      = (state_q == ST_READ);
    pin_cmd        = CMD_NOP;
    bus.sdram_bank = '0;
    bus.sdram_addr = '0;
    unique case (state_q)
      ST_INIT: begin
        pin_cmd        = bus.init_cmd;
        bus.sdram_addr = bus.init_addr;
      end
      ST_AREF: begin
        pin_cmd        = aref_cmd;
        bus.sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        pin_cmd        = bus.wr_cmd;
        bus.sdram_bank = bus.wr_bank;
        bus.sdram_addr = bus.wr_addr;
      end
      ST_READ: begin
        pin_cmd        = bus.rd_cmd;
        bus.sdram_bank = bus.rd_bank;
        bus.sdram_addr = bus.rd_addr;
      end
      default: ;
    endcase
    {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = pin_cmd;
  end

  assign bus.sdram_cke = cke_q;

endmodule
